tt_um_hoene_window_filter: RTL and testbench
============================================

// Module: tt_um_hoene_window_filter
// PURPOSE
//  Multi-channel digital deglitch filter for the smart-LED data inputs, ahead of bit decoding.
//  Per channel: sliding-window majority (K-of-N) or saturating-integrator filter with hysteresis.
//  A runtime mode input selects between the two. Optional sample strobe allows oversampled operation.
//  Emits one-cycle rise/fall pulses aligned with the filtered output. Defaults give 2-of-3 majority.
// PARAMETERS
//  CHANNELS  1  number of independent filtered inputs
//  DEPTH     3  window length (majority) and integrator ceiling; legal range 2..15
//  THRESH    2  majority: out=1 when ones in window >= THRESH; legal range 1..DEPTH
//  HI_TH     3  integrator: level sets when count reaches >= HI_TH; legal range LO_TH+1..DEPTH
//  LO_TH     0  integrator: level clears when count falls to <= LO_TH; legal range 0..HI_TH-1
// PORTS
//  clk    in   1         global clock, all state on rising edge
//  rst_n  in   1         synchronous active-low reset
//  en     in   1         sample strobe; state advances only when 1
//  mode   in   1         0 = majority window, 1 = integrator with hysteresis
//  in     in   CHANNELS  raw input lines (already synchronised upstream)
//  out    out  CHANNELS  filtered level, registered
//  rise   out  CHANNELS  1-cycle pulse when out goes 0->1
//  fall   out  CHANNELS  1-cycle pulse when out goes 1->0
// BEHAVIOUR
//  - Reset: rst_n sampled synchronously on clk, active low; clock is clk.
//  - Reset values: history=0, count=0, level=0, out=0, rise=0, fall=0. Reset overrides en and mode.
//  - Both engines run every enabled cycle regardless of mode; mode only selects which engine feeds out.
//  - Majority window:
//    - hist is DEPTH-1 bits per channel; window = {in, hist}.
//    - maj_next = (popcount(window) >= THRESH); hist shifts in `in` when en=1.
//  - Integrator (count width CW = $clog2(DEPTH+1)):
//    - in=1: count+1, saturating at DEPTH. in=0: count-1, saturating at 0. No wrap-around.
//    - level <= 1 if count_next >= HI_TH; 0 if count_next <= LO_TH; else hold.
//  - Output and pulses:
//    - en=1: out <= mode ? level_next : maj_next; rise <= ~out & new; fall <= out & ~new.
//    - Latency: one clk from the sampled input to out; rise/fall asserted in the same cycle out changes.
//    - en=0: all state and out hold; rise=fall=0 that cycle.
//  - Mode switch: takes effect at the next enabled edge. out may step to the other engine's value,
//    producing a legal rise/fall pulse. No state is flushed.
//  - Reset mid-operation: all channels clear the next cycle. No pulse is generated by reset itself.
//  - Channels are fully independent; no cross-channel logic.
//  - Illegal parameter combinations stop elaboration via a generate-time $error.
// STRUCTURE
//  - Shared package tt_um_hoene_filter_pkg:
//    - mode constants MODE_MAJORITY=1'b0, MODE_INTEGRATOR=1'b1
//    - function popcount and function cnt_width(depth)
//  - Sub-module tt_um_hoene_window_filter_ch: one channel, containing both engines plus out/rise/fall
//    registers. The top level instantiates CHANNELS copies via generate and drives en/mode in common.
// TESTING
//  1. Defaults, mode=0, en=1, in: 0,1,0,0 -> out stays 0; in: 1,1 -> out=1 one cycle after the 2nd 1, rise=1 for 1 cycle.
//  2. DEPTH=5, THRESH=3, mode=0, in pattern 1,0,1,0,1 -> out=1 after 5th sample; isolated 0 next -> out stays 1.
//  3. mode=1, DEPTH=4, HI_TH=3, LO_TH=1: 1,1,1 -> count=3, out=1, rise; 0 -> count=2, out=1 held;
//     0 -> count=1, out=0, fall. 1 x10 -> count saturates at 4.
//  4. en toggling 1,0,0,1 with in=1 throughout (defaults) -> state advances only on en=1 cycles;
//     rise/fall=0 while en=0.
//  5. out=1 steady, rst_n=0 for 1 cycle -> next cycle out=0, rise=0, fall=0, count=0;
//     after release, refilter from scratch.
//  6. CHANNELS=4, independent patterns per bit plus a mode flip mid-stream -> per-channel results match
//     a reference model; no crosstalk.

Source files
------------

// File: rtl/tt_um_hoene_filter_pkg.sv
// Shared definitions for the smart-LED input deglitch filter.
//   MODE_MAJORITY / MODE_INTEGRATOR : values of the runtime mode input
//   popcount(v)                     : number of ones in a 16-bit vector
//   cnt_width(depth)                : integrator counter width able to hold 0..depth
package tt_um_hoene_filter_pkg;

  localparam logic MODE_MAJORITY   = 1'b0;
  localparam logic MODE_INTEGRATOR = 1'b1;

  function automatic int popcount(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tt_um_hoene_window_filter_ch.sv
// One filter channel: K-of-N majority window and saturating integrator with
// hysteresis, both always running; mode picks which one drives out.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : sample strobe, state advances only when high
//   mode       : 0 majority, 1 integrator
//   in         : raw (already synchronised) input
//   out        : filtered level, registered
//   rise/fall  : one-cycle pulses coincident with out changing
module tt_um_hoene_window_filter_ch
  import tt_um_hoene_filter_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int THRESH = 2,
  parameter int HI_TH  = 3,
  parameter int LO_TH  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic mode,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] HI_C    = CW'(HI_TH);
  localparam logic [CW-1:0] LO_C    = CW'(LO_TH);

  logic [DEPTH-2:0] hist;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             level;
  logic             level_next;
  logic             maj_next;
  logic             out_next;
  logic [15:0]      window;

  always_comb begin
    window = '0;
    window[DEPTH-1:0] = {in, hist};
    maj_next = (popcount(window) >= THRESH);

    count_next = count;
    if (in) begin
      if (count != CNT_MAX) count_next = count + CW'(1);
    end else begin
      if (count != '0) count_next = count - CW'(1);
    end

    // Between the thresholds the level keeps its previous value (hysteresis).
    level_next = level;
    if (count_next >= HI_C)      level_next = 1'b1;
    else if (count_next <= LO_C) level_next = 1'b0;

    out_next = (mode == MODE_INTEGRATOR) ? level_next : maj_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist  <= '0;
      count <= '0;
      level <= 1'b0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else if (en) begin
      // Oldest sample drops off; bit order inside hist is irrelevant to popcount.
      hist  <= window[DEPTH-1:1];
      count <= count_next;
      level <= level_next;
      out   <= out_next;
      rise  <= ~out & out_next;
      fall  <= out & ~out_next;
    end else begin
      rise  <= 1'b0;
      fall  <= 1'b0;
    end
  end

endmodule

// File: rtl/tt_um_hoene_window_filter.sv
// Multi-channel deglitch filter for smart-LED data inputs.
//   clk, rst_n     : clock, synchronous active-low reset
//   en             : common sample strobe
//   mode           : common engine select (0 majority, 1 integrator)
//   in[CHANNELS]   : raw inputs
//   out[CHANNELS]  : filtered levels
//   rise/fall      : per-channel edge pulses
module tt_um_hoene_window_filter
  import tt_um_hoene_filter_pkg::*;
#(
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 3,
  parameter int THRESH   = 2,
  parameter int HI_TH    = 3,
  parameter int LO_TH    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  if (CHANNELS < 1 || DEPTH < 2 || DEPTH > 15 || THRESH < 1 || THRESH > DEPTH ||
      LO_TH < 0 || HI_TH <= LO_TH || HI_TH > DEPTH) begin : g_bad_params
    $error("tt_um_hoene_window_filter: illegal parameter combination");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    tt_um_hoene_window_filter_ch #(
      .DEPTH (DEPTH),
      .THRESH(THRESH),
      .HI_TH (HI_TH),
      .LO_TH (LO_TH)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .mode (mode),
      .in   (in[g]),
      .out  (out[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

endmodule

// File: tb/tb_tt_um_hoene_window_filter.sv
// Bench for tt_um_hoene_window_filter: three instances (defaults, DEPTH=5/THRESH=3,
// 4-channel DEPTH=4/HI=3/LO=1) share clk/rst_n/en/mode. A sample-history model
// is checked every cycle, plus literal expectations on the directed sequences.
module tb_tt_um_hoene_window_filter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic in_a = 1'b0;
  logic in_b = 1'b0;
  logic [3:0] in_c = '0;
  logic out_a, rise_a, fall_a, out_b, rise_b, fall_b;
  logic [3:0] out_c, rise_c, fall_c;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  tt_um_hoene_window_filter u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a)
  );

  tt_um_hoene_window_filter #(.DEPTH(5), .THRESH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b)
  );

  tt_um_hoene_window_filter #(.CHANNELS(4), .DEPTH(4), .THRESH(2), .HI_TH(3), .LO_TH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c)
  );

  // ---------------- reference model: lanes 0=u_a, 1=u_b, 2..5=u_c ch0..3
  localparam int P_D[6] = '{3, 5, 4, 4, 4, 4};
  localparam int P_T[6] = '{2, 3, 2, 2, 2, 2};
  localparam int P_H[6] = '{3, 3, 3, 3, 3, 3};
  localparam int P_L[6] = '{0, 0, 1, 1, 1, 1};

  int m_hist[6][16];   // previous samples, index 0 = most recent
  int m_cnt[6];
  bit m_lvl[6], m_out[6], m_rise[6], m_fall[6];
  int mx, mones;
  bit mnew;

  function automatic bit lane_in(input int l);
    if (l == 0) return in_a;
    if (l == 1) return in_b;
    return in_c[l-2];
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < 6; l++) begin
      if (!rst_n) begin
        for (int k = 0; k < 16; k++) m_hist[l][k] = 0;
        m_cnt[l] = 0; m_lvl[l] = 0; m_out[l] = 0; m_rise[l] = 0; m_fall[l] = 0;
      end else if (en) begin
        mx = int'(lane_in(l));
        mones = mx;
        for (int k = 0; k < P_D[l] - 1; k++) mones += m_hist[l][k];
        for (int k = P_D[l] - 2; k > 0; k--) m_hist[l][k] = m_hist[l][k-1];
        m_hist[l][0] = mx;
        if (mx == 1) m_cnt[l] = (m_cnt[l] + 1 > P_D[l]) ? P_D[l] : m_cnt[l] + 1;
        else         m_cnt[l] = (m_cnt[l] - 1 < 0) ? 0 : m_cnt[l] - 1;
        if (m_cnt[l] >= P_H[l])      m_lvl[l] = 1;
        else if (m_cnt[l] <= P_L[l]) m_lvl[l] = 0;
        mnew = mode ? m_lvl[l] : (mones >= P_T[l]);
        m_rise[l] = !m_out[l] && mnew;
        m_fall[l] = m_out[l] && !mnew;
        m_out[l] = mnew;
      end else begin
        m_rise[l] = 0; m_fall[l] = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [5:0] d_out, d_rise, d_fall;
  assign d_out  = {out_c, out_b, out_a};
  assign d_rise = {rise_c, rise_b, rise_a};
  assign d_fall = {fall_c, fall_b, fall_a};

  always @(negedge clk) begin
    if (chk_on) begin
      for (int l = 0; l < 6; l++) begin
        check($sformatf("model_out[%0d]", l),  32'(d_out[l]),  32'(m_out[l]));
        check($sformatf("model_rise[%0d]", l), 32'(d_rise[l]), 32'(m_rise[l]));
        check($sformatf("model_fall[%0d]", l), 32'(d_fall[l]), 32'(m_fall[l]));
      end
    end
  end

  // ---------------- directed sequences
  bit s1_in[6]   = '{0, 1, 0, 0, 1, 1};
  bit s1_out[6]  = '{0, 0, 0, 0, 0, 1};
  // 1,0,1,0,1 reaches 3-of-5; then 1 and an isolated 0 keep at least 3 ones in the window.
  bit s2_in[7]   = '{1, 0, 1, 0, 1, 1, 0};
  bit s2_out[7]  = '{0, 0, 0, 0, 1, 1, 1};
  bit s3_in[5]   = '{1, 1, 1, 0, 0};
  bit s3_out[5]  = '{0, 0, 1, 1, 0};
  int s3_cnt[5]  = '{1, 2, 3, 2, 1};
  bit s4_en[4]   = '{1, 0, 0, 1};
  bit s4_out[4]  = '{0, 0, 0, 1};
  logic [3:0] s6_c[24] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'hF, 4'hD, 4'h5, 4'hA,
                           4'hE, 4'h0, 4'h8, 4'h9, 4'hF, 4'hF, 4'hB, 4'h4,
                           4'h0, 4'h2, 4'h7, 4'h1, 4'hC, 4'h0, 4'h0, 4'h6};

  task automatic tick(input logic a, input logic b, input logic [3:0] c);
    in_a = a; in_b = b; in_c = c;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b0;
    tick(0, 0, 4'h0);
    chk_on = 1'b1;
    check("reset_out_a", 32'(out_a), 0);
    check("reset_rise_a", 32'(rise_a), 0);
    check("reset_out_c", 32'(out_c), 0);
    check("reset_count_c0", 32'(u_c.g_ch[0].u_ch.count), 0);

    // 1: default 2-of-3 majority
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(s1_in[i], 0, 4'h0);
      check($sformatf("maj3_out[%0d]", i), 32'(out_a), 32'(s1_out[i]));
      check($sformatf("maj3_rise[%0d]", i), 32'(rise_a), 32'(s1_out[i]));
    end
    tick(1, 0, 4'h0);
    check("maj3_hold_out", 32'(out_a), 1);
    check("maj3_hold_rise", 32'(rise_a), 0);

    // 2: 3-of-5 majority; reset while out_a=1 must not pulse fall
    rst_n = 1'b0;
    tick(0, 0, 4'h0);
    check("rst_no_fall_a", 32'(fall_a), 0);
    check("rst_out_a", 32'(out_a), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(0, s2_in[i], 4'h0);
      check($sformatf("maj5_out[%0d]", i), 32'(out_b), 32'(s2_out[i]));
    end

    // 3: integrator with hysteresis on u_c ch0
    rst_n = 1'b0;
    tick(0, 0, 4'h0);
    rst_n = 1'b1; mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, {3'b010, s3_in[i]});
      check($sformatf("int_out[%0d]", i), 32'(out_c[0]), 32'(s3_out[i]));
      check($sformatf("int_cnt[%0d]", i), 32'(u_c.g_ch[0].u_ch.count), 32'(s3_cnt[i]));
    end
    check("int_fall", 32'(fall_c[0]), 1);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 4'h1);
      check($sformatf("int_sat_cnt[%0d]", i), 32'(u_c.g_ch[0].u_ch.count), (i + 2 > 4) ? 4 : i + 2);
    end
    check("int_sat_out", 32'(out_c[0]), 1);

    // 4: en gating, defaults, in=1 throughout
    rst_n = 1'b0;
    tick(0, 0, 4'h0);
    rst_n = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = s4_en[i];
      tick(1, 0, 4'hF);
      check($sformatf("en_out[%0d]", i), 32'(out_a), 32'(s4_out[i]));
      check($sformatf("en_rise[%0d]", i), 32'(rise_a), 32'(s4_out[i]));
    end

    // 5: reset from steady out=1
    en = 1'b1;
    tick(1, 0, 4'hF);
    check("steady_out", 32'(out_a), 1);
    rst_n = 1'b0;
    tick(1, 0, 4'hF);
    check("midrst_out", 32'(out_a), 0);
    check("midrst_rise", 32'(rise_a), 0);
    check("midrst_fall", 32'(fall_a), 0);
    check("midrst_cnt", 32'(u_c.g_ch[0].u_ch.count), 0);
    rst_n = 1'b1;
    tick(1, 0, 4'h0);
    check("refilter_out0", 32'(out_a), 0);
    tick(1, 0, 4'h0);
    check("refilter_out1", 32'(out_a), 1);
    check("refilter_rise", 32'(rise_a), 1);

    // 6: four channels with mode flip and en gaps, model-checked
    rst_n = 1'b0;
    tick(0, 0, 4'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      mode = (i >= 12);
      en = !(i == 7 || i == 18);
      tick(i[0], i[1], s6_c[i]);
    end
    tick(0, 0, 4'h0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
